// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor controller: one full-subtractor cell
// time-shared LSB first under a start/busy/done handshake.
// Ports: clk, reset (async, active-high), start, a, b -> busy, done,
//   diff (a-b mod 2^WIDTH), borrow_out (a<b unsigned), and ovf (signed
//   overflow) only when SERIAL_SUB_OVF_EN is defined.
module serial_sub_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-2:0] res;
  logic             bin;
  logic [CNT_W-1:0] cnt;

  logic             ai;
  logic             bi;
  logic             hx;
  logic             d;
  logic             bout;
  logic             last;
  logic [WIDTH-1:0] res_nxt;

  // Two half-subtractor stages joined by the borrow OR.
  assign ai      = ra[0];
  assign bi      = rb[0];
  assign hx      = ai ^ bi;
  assign d       = hx ^ bin;
  assign bout    = (~ai & bi) | (~hx & bin);
  assign last    = (cnt == CNT_W'(WIDTH - 1));
  assign res_nxt = {d, res};

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ra         <= '0;
      rb         <= '0;
      res        <= '0;
      bin        <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf        <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            ra    <= a;
            rb    <= b;
            bin   <= 1'b0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          ra  <= {1'b0, ra[WIDTH-1:1]};
          rb  <= {1'b0, rb[WIDTH-1:1]};
          res <= res_nxt[WIDTH-1:1];
          bin <= bout;
          if (last) begin
            state      <= DONE;
            diff       <= res_nxt;
            borrow_out <= bout;
`ifdef SERIAL_SUB_OVF_EN
            // On the last bit ra[0]/rb[0] hold the operand MSBs.
            ovf        <= (ai ^ bi) & (ai ^ d);
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=8): directed and random
// operations compared with an arithmetic reference model.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] m_diff(input int x, input int y);
    int r;
    r = (x - y + 256) % 256;
    return r[W-1:0];
  endfunction

  function automatic logic m_borrow(input int x, input int y);
    return x < y;
  endfunction

  function automatic logic m_ovf(input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    int s;
    s = int'($signed(x)) - int'($signed(y));
    return (s > 127) || (s < -128);
  endfunction

  // One operation: start at a negedge, accepted at the next posedge.
  task automatic do_op(input logic [W-1:0] x,
                       input logic [W-1:0] y,
                       input bit repulse);
    int lat;
    int bcnt;
    int held;
    logic [W-1:0] pd;
    logic pb;
    pd = diff;
    pb = borrow_out;
    held = 1;
    @(negedge clk);
    start = 1'b1;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    lat = 0;
    bcnt = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      if (diff !== pd || borrow_out !== pb) held = 0;
      if (repulse && lat == 3) begin
        start = 1'b1;
        a = 8'h77;
        b = 8'h11;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    if (busy) bcnt++;
    chk("latency", lat, W);
    chk("held_during_shift", held, 1);
    chk("diff", diff, m_diff(int'(x), int'(y)));
    chk("borrow", borrow_out, m_borrow(int'(x), int'(y)));
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf", ovf, m_ovf(x, y));
`endif
    @(posedge clk);
    #1;
    chk("busy_cycles", bcnt, W + 1);
    chk("idle_after", {busy, done}, 2'b00);
    chk("diff_held", diff, m_diff(int'(x), int'(y)));
  endtask

  initial begin
    int dcnt;
    int dpos[$];
    logic [W-1:0] rx;
    logic [W-1:0] ry;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {busy, done, diff, borrow_out}, '0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #3 reset = 1'b0;
    #1;
    chk("rst_pulse", {busy, done, diff, borrow_out}, '0);

    do_op(8'h05, 8'h03, 1'b0);
    do_op(8'h03, 8'h05, 1'b0);
    do_op(8'h00, 8'h00, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b0);
    do_op(8'h80, 8'h01, 1'b0);
    do_op(8'h7F, 8'hFF, 1'b0);
    do_op(8'h10, 8'h01, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("repulse_ignored", busy, 1'b0);

    // Reset in the 4th SHIFT cycle abandons the operation.
    do_op(8'h03, 8'h05, 1'b0);
    @(negedge clk);
    start = 1'b1;
    a = 8'h40;
    b = 8'h01;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst", {busy, done, diff, borrow_out}, '0);
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    chk("no_done_after_rst", dcnt, 0);
    do_op(8'h09, 8'h04, 1'b0);

    // start held high: one acceptance every W+2 cycles.
    @(negedge clk);
    start = 1'b1;
    a = 8'h20;
    b = 8'h08;
    @(posedge clk);
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dpos.push_back(i);
        chk("b2b_diff", diff, 8'h18);
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("b2b_count", dpos.size(), 3);
    if (dpos.size() == 3) begin
      chk("b2b_first", dpos[0], W);
      chk("b2b_gap1", dpos[1] - dpos[0], W + 2);
      chk("b2b_gap2", dpos[2] - dpos[1], W + 2);
    end
    repeat (W + 3) @(posedge clk);

    for (int i = 0; i < 40; i++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      if (i % 8 == 0) ry = rx;
      do_op(rx, ry, ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
